// File: rtl/hack_pkg.sv
// Shared Hack platform definitions for the keyboard port.
// Holds the memory-mapped keyboard address, the Hack key-code constants
// and the PS/2 frame-state enumeration.
package hack_pkg;

  localparam logic [14:0] KBD_ADDR = 15'h6000;

  // PS/2 set-2 prefix bytes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Hack key codes
  localparam logic [15:0] KEY_NONE      = 16'd0;
  localparam logic [15:0] KEY_SPACE     = 16'd32;
  localparam logic [15:0] KEY_0         = 16'd48;
  localparam logic [15:0] KEY_A         = 16'd65;
  localparam logic [15:0] KEY_ENTER     = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_HOME      = 16'd134;
  localparam logic [15:0] KEY_END       = 16'd135;
  localparam logic [15:0] KEY_PGUP      = 16'd136;
  localparam logic [15:0] KEY_PGDN      = 16'd137;
  localparam logic [15:0] KEY_INS       = 16'd138;
  localparam logic [15:0] KEY_DEL       = 16'd139;
  localparam logic [15:0] KEY_ESC       = 16'd140;
  localparam logic [15:0] KEY_F1        = 16'd141;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } kbd_state_e;

endpackage

// File: rtl/hack_kbd_port_if.sv
// CPU-side bus of the keyboard port.
//   address   : CPU data address (addressM)
//   kbd_hit   : address decodes to the keyboard register
//   key_out   : Hack code of the held key, 0 when none
//   frame_err : one-cycle pulse on a rejected PS/2 frame
// master = CPU / memory side, slave = keyboard port.
interface hack_kbd_port_if;
  logic [14:0] address;
  logic        kbd_hit;
  logic [15:0] key_out;
  logic        frame_err;

  modport master (
    output address,
    input  kbd_hit,
    input  key_out,
    input  frame_err
  );

  modport slave (
    input  address,
    output kbd_hit,
    output key_out,
    output frame_err
  );
endinterface

// File: rtl/hack_ps2_keymap.sv
// Combinational PS/2 set-2 scan code to Hack key code lookup.
//   ext_i  : byte was preceded by the 0xE0 prefix
//   byte_i : scan code byte
//   code_o : Hack key code, 0 for unmapped bytes
module hack_ps2_keymap
  import hack_pkg::*;
(
  input  logic        ext_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] code_o
);

  always_comb begin
    code_o = KEY_NONE;
    if (ext_i) begin
      case (byte_i)
        8'h6B:   code_o = KEY_LEFT;
        8'h75:   code_o = KEY_UP;
        8'h74:   code_o = KEY_RIGHT;
        8'h72:   code_o = KEY_DOWN;
        8'h6C:   code_o = KEY_HOME;
        8'h69:   code_o = KEY_END;
        8'h7D:   code_o = KEY_PGUP;
        8'h7A:   code_o = KEY_PGDN;
        8'h70:   code_o = KEY_INS;
        8'h71:   code_o = KEY_DEL;
        default: code_o = KEY_NONE;
      endcase
    end else begin
      case (byte_i)
        8'h1C:   code_o = KEY_A;
        8'h32:   code_o = KEY_A + 16'd1;
        8'h21:   code_o = KEY_A + 16'd2;
        8'h23:   code_o = KEY_A + 16'd3;
        8'h24:   code_o = KEY_A + 16'd4;
        8'h2B:   code_o = KEY_A + 16'd5;
        8'h34:   code_o = KEY_A + 16'd6;
        8'h33:   code_o = KEY_A + 16'd7;
        8'h43:   code_o = KEY_A + 16'd8;
        8'h3B:   code_o = KEY_A + 16'd9;
        8'h42:   code_o = KEY_A + 16'd10;
        8'h4B:   code_o = KEY_A + 16'd11;
        8'h3A:   code_o = KEY_A + 16'd12;
        8'h31:   code_o = KEY_A + 16'd13;
        8'h44:   code_o = KEY_A + 16'd14;
        8'h4D:   code_o = KEY_A + 16'd15;
        8'h15:   code_o = KEY_A + 16'd16;
        8'h2D:   code_o = KEY_A + 16'd17;
        8'h1B:   code_o = KEY_A + 16'd18;
        8'h2C:   code_o = KEY_A + 16'd19;
        8'h3C:   code_o = KEY_A + 16'd20;
        8'h2A:   code_o = KEY_A + 16'd21;
        8'h1D:   code_o = KEY_A + 16'd22;
        8'h22:   code_o = KEY_A + 16'd23;
        8'h35:   code_o = KEY_A + 16'd24;
        8'h1A:   code_o = KEY_A + 16'd25;
        8'h45:   code_o = KEY_0;
        8'h16:   code_o = KEY_0 + 16'd1;
        8'h1E:   code_o = KEY_0 + 16'd2;
        8'h26:   code_o = KEY_0 + 16'd3;
        8'h25:   code_o = KEY_0 + 16'd4;
        8'h2E:   code_o = KEY_0 + 16'd5;
        8'h36:   code_o = KEY_0 + 16'd6;
        8'h3D:   code_o = KEY_0 + 16'd7;
        8'h3E:   code_o = KEY_0 + 16'd8;
        8'h46:   code_o = KEY_0 + 16'd9;
        8'h29:   code_o = KEY_SPACE;
        8'h5A:   code_o = KEY_ENTER;
        8'h66:   code_o = KEY_BACKSPACE;
        8'h76:   code_o = KEY_ESC;
        8'h05:   code_o = KEY_F1;
        8'h06:   code_o = KEY_F1 + 16'd1;
        8'h04:   code_o = KEY_F1 + 16'd2;
        8'h0C:   code_o = KEY_F1 + 16'd3;
        8'h03:   code_o = KEY_F1 + 16'd4;
        8'h0B:   code_o = KEY_F1 + 16'd5;
        8'h83:   code_o = KEY_F1 + 16'd6;
        8'h0A:   code_o = KEY_F1 + 16'd7;
        8'h01:   code_o = KEY_F1 + 16'd8;
        8'h09:   code_o = KEY_F1 + 16'd9;
        8'h78:   code_o = KEY_F1 + 16'd10;
        8'h07:   code_o = KEY_F1 + 16'd11;
        default: code_o = KEY_NONE;
      endcase
    end
  end

endmodule

// File: rtl/hack_kbd_port.sv
// Hack keyboard port: receives PS/2 set-2 frames and presents the currently
// held key as a Hack key code on the memory-mapped keyboard register.
//   clk, reset        : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data : raw keyboard lines (asynchronous to clk)
//   bus               : CPU side (address in; kbd_hit, key_out, frame_err out)
// Optional build macro HACK_KBD_TIMEOUT_EN adds an inter-edge frame timeout of
// CLK_HZ/1000000*TIMEOUT_US clk cycles; without it a partial frame waits forever.
module hack_kbd_port
  import hack_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  hack_kbd_port_if.slave bus
);

  // Synchronizers and falling-edge detect
  logic [1:0] ps2_clk_sync_q, ps2_data_sync_q;
  logic       ps2_clk_prev_q;
  logic       ps2_fall, ps2_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2_clk_sync_q  <= 2'b11;
      ps2_data_sync_q <= 2'b11;
      ps2_clk_prev_q  <= 1'b1;
    end else begin
      ps2_clk_sync_q  <= {ps2_clk_sync_q[0], ps2_clk};
      ps2_data_sync_q <= {ps2_data_sync_q[0], ps2_data};
      ps2_clk_prev_q  <= ps2_clk_sync_q[1];
    end
  end

  assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_sync_q[1];
  assign ps2_bit  = ps2_data_sync_q[1];

  // Frame receiver
  kbd_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        byte_vld_q, byte_vld_d;
  logic        err_q, err_d;
  logic        timeout;

`ifdef HACK_KBD_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned TimeoutW      = $clog2(TimeoutCycles + 1);

  logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;

  assign timeout = (state_q != StIdle) && (to_cnt_q == TimeoutW'(TimeoutCycles));

  always_comb begin
    to_cnt_d = to_cnt_q + TimeoutW'(1);
    if (state_q == StIdle || ps2_fall || timeout) begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{CLK_HZ, TIMEOUT_US};
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    byte_vld_d = 1'b0;
    err_d      = 1'b0;
    if (timeout) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end else if (ps2_fall) begin
      unique case (state_q)
        StIdle: begin
          // A high start bit is line noise; keep waiting.
          if (!ps2_bit) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {ps2_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          parity_d = ps2_bit;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          // Odd parity across data+parity, and stop bit high.
          if (ps2_bit && (^{shift_q, parity_q})) begin
            byte_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Byte decoder; shift_q stays put for the cycle after the stop edge.
  logic [15:0] code;
  logic [15:0] key_q, key_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;

  hack_ps2_keymap u_keymap (
    .ext_i  (ext_q),
    .byte_i (shift_q),
    .code_o (code)
  );

  always_comb begin
    key_d = key_q;
    ext_d = ext_q;
    brk_d = brk_q;
    if (byte_vld_q) begin
      if (shift_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (brk_q) begin
          // Releasing a key other than the held one changes nothing.
          if (code == key_q) begin
            key_d = KEY_NONE;
          end
        end else if (code != KEY_NONE) begin
          key_d = code;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      byte_vld_q <= 1'b0;
      err_q      <= 1'b0;
      key_q      <= KEY_NONE;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      byte_vld_q <= byte_vld_d;
      err_q      <= err_d;
      key_q      <= key_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
    end
  end

  // No CPU write path: address only drives the hit decode.
  assign bus.kbd_hit   = (bus.address == KBD_ADDR);
  assign bus.key_out   = key_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_hack_kbd_port.sv
// Self-checking bench for hack_kbd_port: directed scenarios plus a randomized
// make/break stream scored against a table-driven model of the key register.
module tb_hack_kbd_port;

  localparam int HP = 10;  // PS/2 half period in clk cycles

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  hack_kbd_port_if bus ();

  hack_kbd_port #(
    .CLK_HZ     (1000000),
    .TIMEOUT_US (100)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int err_cycles = 0;

  always @(posedge clk) begin
    if (bus.frame_err === 1'b1) err_cycles <= err_cycles + 1;
  end

  // Reference keymap table
  typedef struct {
    logic       ext;
    logic [7:0] sc;
    int         code;
  } km_t;
  km_t km[$];

  int m_key;
  bit m_ext, m_brk;

  task automatic init_keymap();
    logic [7:0] letters [26];
    logic [7:0] digits [10];
    logic [7:0] fkeys [12];
    logic [7:0] exts [10];
    km_t e;
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    fkeys   = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09,
                8'h78, 8'h07};
    exts    = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
    for (int i = 0; i < 26; i++) begin e.ext = 0; e.sc = letters[i]; e.code = 65 + i;
      km.push_back(e); end
    for (int i = 0; i < 10; i++) begin e.ext = 0; e.sc = digits[i]; e.code = 48 + i;
      km.push_back(e); end
    for (int i = 0; i < 12; i++) begin e.ext = 0; e.sc = fkeys[i]; e.code = 141 + i;
      km.push_back(e); end
    for (int i = 0; i < 10; i++) begin e.ext = 1; e.sc = exts[i]; e.code = 130 + i;
      km.push_back(e); end
    e.ext = 0;
    e.sc = 8'h29; e.code = 32;  km.push_back(e);
    e.sc = 8'h5A; e.code = 128; km.push_back(e);
    e.sc = 8'h66; e.code = 129; km.push_back(e);
    e.sc = 8'h76; e.code = 140; km.push_back(e);
  endtask

  function automatic int ref_code(input bit ext, input logic [7:0] b);
    foreach (km[i]) if (km[i].ext == ext && km[i].sc == b) return km[i].code;
    return 0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int code;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      code = ref_code(m_ext, b);
      if (m_brk) begin
        if (code == m_key) m_key = 0;
      end else if (code != 0) m_key = code;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // PS/2 drivers
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par,
                                           input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ps2_bit(f[i]);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(mk_frame(b, 0, 0), 0, 10);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    m_key = 0; m_ext = 0; m_brk = 0;
  endtask

  // Tests
  task automatic test_reset();
    ps2_clk = 1'b1; ps2_data = 1'b1; bus.address = 15'h0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.key_out !== 16'd0) begin n_fail++;
      $display("FAIL reset_key: got %0d expected 0", bus.key_out); end
    n_checks++;
    if (bus.frame_err !== 1'b0) begin n_fail++;
      $display("FAIL reset_err: got %b expected 0", bus.frame_err); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_kbd_hit();
    logic [14:0] a;
    bus.address = 15'h6000; #1;
    n_checks++;
    if (bus.kbd_hit !== 1'b1) begin n_fail++;
      $display("FAIL hit_6000: got %b expected 1", bus.kbd_hit); end
    bus.address = 15'h6001; #1;
    n_checks++;
    if (bus.kbd_hit !== 1'b0) begin n_fail++;
      $display("FAIL hit_6001: got %b expected 0", bus.kbd_hit); end
    for (int i = 0; i < 8; i++) begin
      a = 15'($urandom);
      if (i == 3) a = 15'h2000;
      bus.address = a; #1;
      n_checks++;
      if (bus.kbd_hit !== (a == 15'h6000)) begin n_fail++;
        $display("FAIL hit_rand: addr %h got %b expected %b", a, bus.kbd_hit, a == 15'h6000);
      end
    end
    bus.address = 15'h6000;
  endtask

  task automatic test_make_latency();
    logic [10:0] f;
    int n;
    do_reset();
    f = mk_frame(8'h1C, 0, 0);
    send_bits(f, 0, 9);
    ps2_data = f[10];
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b0;
    n = 0;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
      if (bus.key_out !== 16'd0) break;
    end
    n_checks++;
    if (n != 4) begin n_fail++;
      $display("FAIL make_latency: got %0d cycles expected 4", n); end
    n_checks++;
    if (bus.key_out !== 16'd65) begin n_fail++;
      $display("FAIL make_1c: got %0d expected 65", bus.key_out); end
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_make_break();
    do_reset();
    send_frame(8'h1C); send_frame(8'hF0); send_frame(8'h1C);
    n_checks++;
    if (bus.key_out !== 16'd0) begin n_fail++;
      $display("FAIL break_a: got %0d expected 0", bus.key_out); end
    send_frame(8'h1C); send_frame(8'h32);
    n_checks++;
    if (bus.key_out !== 16'd66) begin n_fail++;
      $display("FAIL make_b: got %0d expected 66", bus.key_out); end
    send_frame(8'hF0); send_frame(8'h1C);
    n_checks++;
    if (bus.key_out !== 16'd66) begin n_fail++;
      $display("FAIL break_other: got %0d expected 66", bus.key_out); end
  endtask

  task automatic test_extended();
    do_reset();
    send_frame(8'hE0);
    n_checks++;
    if (bus.key_out !== 16'd0) begin n_fail++;
      $display("FAIL ext_prefix: got %0d expected 0", bus.key_out); end
    send_frame(8'h75);
    n_checks++;
    if (bus.key_out !== 16'd131) begin n_fail++;
      $display("FAIL ext_up: got %0d expected 131", bus.key_out); end
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    n_checks++;
    if (bus.key_out !== 16'd0) begin n_fail++;
      $display("FAIL ext_up_break: got %0d expected 0", bus.key_out); end
  endtask

  task automatic test_frame_err();
    int e0;
    do_reset();
    send_frame(8'h32);
    e0 = err_cycles;
    send_bits(mk_frame(8'h1C, 1, 0), 0, 10);
    repeat (4) @(negedge clk);
    n_checks++;
    if (err_cycles - e0 != 1) begin n_fail++;
      $display("FAIL parity_err_pulse: got %0d cycles expected 1", err_cycles - e0); end
    n_checks++;
    if (bus.key_out !== 16'd66) begin n_fail++;
      $display("FAIL parity_err_key: got %0d expected 66", bus.key_out); end
    e0 = err_cycles;
    send_bits(mk_frame(8'h29, 0, 1), 0, 10);
    repeat (4) @(negedge clk);
    n_checks++;
    if (err_cycles - e0 != 1 || bus.key_out !== 16'd66) begin n_fail++;
      $display("FAIL stop_err: got %0d pulses key %0d expected 1 pulse key 66",
               err_cycles - e0, bus.key_out); end
    send_frame(8'h29);
    n_checks++;
    if (bus.key_out !== 16'd32) begin n_fail++;
      $display("FAIL space_after_err: got %0d expected 32", bus.key_out); end
  endtask

  task automatic test_stall();
    int e0;
    logic [10:0] f;
    do_reset();
    e0 = err_cycles;
`ifdef HACK_KBD_TIMEOUT_EN
    send_bits(mk_frame(8'h1C, 0, 0), 0, 4);
    ps2_data = 1'b1;
    repeat (300) @(negedge clk);
    n_checks++;
    if (err_cycles - e0 != 1 || bus.key_out !== 16'd0) begin n_fail++;
      $display("FAIL timeout: got %0d pulses key %0d expected 1 pulse key 0",
               err_cycles - e0, bus.key_out); end
    send_frame(8'h45);
    n_checks++;
    if (bus.key_out !== 16'd48) begin n_fail++;
      $display("FAIL after_timeout: got %0d expected 48", bus.key_out); end
`else
    f = mk_frame(8'h45, 0, 0);
    send_bits(f, 0, 4);
    repeat (300) @(negedge clk);
    n_checks++;
    if (err_cycles - e0 != 0 || bus.key_out !== 16'd0) begin n_fail++;
      $display("FAIL stall_hold: got %0d pulses key %0d expected 0 pulses key 0",
               err_cycles - e0, bus.key_out); end
    send_bits(f, 5, 10);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.key_out !== 16'd48) begin n_fail++;
      $display("FAIL stall_resume: got %0d expected 48", bus.key_out); end
`endif
  endtask

  task automatic test_reset_midframe();
    int e0;
    logic [10:0] f;
    do_reset();
    send_frame(8'h1C);
    f = mk_frame(8'hFF, 0, 0);
    send_bits(f, 0, 3);
    e0 = err_cycles;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.key_out !== 16'd0 || bus.frame_err !== 1'b0) begin n_fail++;
      $display("FAIL midframe_reset: got key %0d err %b expected key 0 err 0",
               bus.key_out, bus.frame_err); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send_bits(f, 4, 10);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.key_out !== 16'd0 || err_cycles != e0) begin n_fail++;
      $display("FAIL abandoned_tail: got key %0d pulses %0d expected key 0 pulses 0",
               bus.key_out, err_cycles - e0); end
    send_frame(8'h5A);
    n_checks++;
    if (bus.key_out !== 16'd128) begin n_fail++;
      $display("FAIL enter_after_reset: got %0d expected 128", bus.key_out); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r, e0, exp_err;
    bit bad_par, bad_stop;
    do_reset();
    for (int step = 0; step < 80; step++) begin
      r = $urandom_range(0, 99);
      if (r < 10) b = 8'hE0;
      else if (r < 25) b = 8'hF0;
      else if (r < 90) b = km[$urandom_range(0, km.size() - 1)].sc;
      else b = 8'($urandom);
      bad_par = 0; bad_stop = 0;
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) bad_par = 1; else bad_stop = 1;
      end
      exp_err = (bad_par || bad_stop) ? 1 : 0;
      if (exp_err == 0) model_byte(b);
      e0 = err_cycles;
      send_bits(mk_frame(b, bad_par, bad_stop), 0, 10);
      repeat (4) @(negedge clk);
      n_checks++;
      if (bus.key_out !== m_key[15:0]) begin n_fail++;
        $display("FAIL rand_key step %0d byte %h: got %0d expected %0d",
                 step, b, bus.key_out, m_key); end
      n_checks++;
      if (err_cycles - e0 != exp_err) begin n_fail++;
        $display("FAIL rand_err step %0d byte %h: got %0d pulses expected %0d",
                 step, b, err_cycles - e0, exp_err); end
    end
  endtask

  initial begin
    init_keymap();
    test_reset();
    test_kbd_hit();
    test_make_latency();
    test_make_break();
    test_extended();
    test_frame_err();
    test_stall();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_kbd_port.md
HACK_KBD_PORT -- requirements
Module: hack_kbd_port

Interface
- REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning system clock frequency used to size the frame timeout.
- REQ-002 SHALL have parameter TIMEOUT_US, default 2000, meaning the maximum gap between PS/2 clock falling edges within one frame.
- REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state is on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-005 SHALL have port ps2_clk, input, 1 bit: keyboard clock, asynchronous to clk.
- REQ-006 SHALL have port ps2_data, input, 1 bit: keyboard data, asynchronous to clk.
- REQ-007 SHALL have port address, input, 15 bits: CPU data address (addressM).
- REQ-008 SHALL have port kbd_hit, output, 1 bit: combinational, high when address == 15'h6000.
- REQ-009 SHALL have port key_out, output, 16 bits: registered Hack key code of the currently held key, 0 when none is held.
- REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on any rejected frame.

Function
- REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers and act only on a synchronized ps2_clk falling edge.
- REQ-012 SHALL run the frame state machine IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, advancing one state or bit per falling edge.
- REQ-013 SHALL stay in IDLE if the start bit sampled in IDLE is 1.
- REQ-014 SHALL require odd parity over the data bits plus the parity bit, and a stop bit of 1; on failure it SHALL discard the byte, pulse frame_err, and return to IDLE.
- REQ-015 SHALL treat a byte 0xE0 as setting the ext flag and a byte 0xF0 as setting the brk flag, with no change to key_out for either.
- REQ-016 For any other byte, SHALL look up code = keymap(ext, byte) and then clear both ext and brk.
- REQ-017 Make code: if code != 0, SHALL set key_out <= code, with the most recent make winning; unmapped bytes (code 0) SHALL leave key_out unchanged.
- REQ-018 Break code: if code == key_out, SHALL set key_out <= 0; otherwise key_out SHALL be unchanged.
- REQ-019 key_out SHALL update exactly 1 clk after the synchronized stop-bit edge.
- REQ-020 Keymap: letters SHALL map to 65..90 (uppercase only), digits to 48..57, space to 32, enter to 128, backspace to 129, left/up/right/down to 130..133, home/end to 134/135, pgup/pgdn to 136/137, ins/del to 138/139, esc to 140, and F1..F12 to 141..152.
- REQ-021 SHALL provide no CPU write path; writes to 0x6000 SHALL have no effect on the block.
- REQ-022 key_out SHALL be held stable regardless of address; hack_memory performs the read mux.

Reset
- REQ-023 While reset == 0, SHALL force the state machine to IDLE, and clear the bit counter, shift register, ext, brk, the timeout counter, key_out (0), and frame_err (0).
- REQ-024 A reset asserted mid-frame SHALL abandon that frame; after release, the first accepted frame SHALL be one with a fresh start bit.

Configuration
- REQ-025 With HACK_KBD_TIMEOUT_EN defined, a counter SHALL reset on every falling edge outside IDLE; on reaching CLK_HZ/1000000*TIMEOUT_US it SHALL force IDLE and pulse frame_err.
- REQ-026 With HACK_KBD_TIMEOUT_EN undefined, there SHALL be no counter and no timeout: a partial frame waits indefinitely.

Structure
- REQ-027 The shared package hack_pkg SHALL hold the KBD_ADDR (15'h6000) constant, the Hack key-code constants, and the frame-state enumeration.
- REQ-028 The sub-module hack_ps2_keymap SHALL be purely combinational, mapping (ext, byte[7:0]) to code[15:0].

Verification
- REQ-029 The bench SHALL check: frame 0x1C (parity 0) -> key_out = 65 one clk after stop; address = 15'h6000 -> kbd_hit = 1; address = 15'h6001 -> kbd_hit = 0.
- REQ-030 The bench SHALL check: 0x1C, then 0xF0, 0x1C -> key_out returns to 0; 0x1C, 0x32, then 0xF0, 0x1C -> key_out stays 66.
- REQ-031 The bench SHALL check: 0xE0, 0x75 -> key_out = 131; then 0xE0, 0xF0, 0x75 -> key_out = 0.
- REQ-032 The bench SHALL check: 0x1C with parity bit 1 -> frame_err pulses once, key_out unchanged; next good 0x29 -> key_out = 32.
- REQ-033 The bench SHALL check, with HACK_KBD_TIMEOUT_EN: 5 bits then a stall longer than TIMEOUT_US -> frame_err pulse, state IDLE; next good 0x45 -> key_out = 48.
- REQ-034 The bench SHALL check: reset pulsed after 4 bits of a frame -> key_out = 0 and frame_err = 0; the trailing bits of the abandoned frame are not decoded; the next full 0x5A frame -> key_out = 128.
